instr_cache_refill_ctrl: RTL
============================

// Module: instr_cache_refill_ctrl
// PURPOSE
//  Miss/refill controller for the 2-way instruction cache. Watches tag-compare hit flags for the fetch line
//  (and the next line when a fetch straddles), bursts missing lines from memory, and drives the per-beat
//  write strobes/index consumed by the LRU replacement stage and both data/tag arrays. Stalls the fetch unit.
// PARAMETERS
//  idx_size   6   index bits; block_no = 2**idx_size lines per set
//  block_no   64  lines per set
//  addr_width 32  byte address width
//  data_width 32  memory beat / instruction word width
//  words      4   beats (words) per line, power of two >= 2
// PORTS
//  clk_i        in   1           clock, all state on rising edge
//  rst_ni       in   1           asynchronous active-low reset
//  req_i        in   1           fetch request valid
//  addr_i       in   addr_width  fetch byte address {tag,idx,offset}
//  need_next_i  in   1           fetch straddles into line idx+1
//  hit_i        in   1           hit in set1 or set2 for current line
//  hit_next_i   in   1           hit in set1 or set2 for line idx+1
//  mem_req_o    out  1           line read request, held until grant
//  mem_addr_o   out  addr_width  line-aligned request address
//  mem_gnt_i    in   1           memory accepted request this cycle
//  mem_rvalid_i in   1           one beat valid on mem_rdata_i
//  mem_rdata_i  in   data_width  beat data, ascending word order
//  write_o      out  1           array write this cycle
//  instr_write_start_o out 1     high with write_o on beat 0 only
//  idx_o        out  idx_size    line index being filled
//  tag_o        out  addr_width-idx_size-log2(words)-2  tag of line being filled
//  word_o       out  log2(words) word slot being written
//  wdata_o      out  data_width  data to arrays (= mem_rdata_i)
//  stall_o      out  1           fetch unit must hold req/addr
// BEHAVIOUR
//  Reset: state IDLE; mem_req_o, write_o, instr_write_start_o, stall_o = 0; idx_o/tag_o/word_o/mem_addr_o = 0.
//  States: IDLE, REQ, FILL, DONE. Register 'second' marks the current fill as the idx+1 line.
//  IDLE: miss = req_i & (~hit_i | need_next_i & ~hit_next_i). stall_o = miss (combinational).
//   On miss: capture line (current line if ~hit_i, else idx+1); second = hit_i; -> REQ.
//  REQ: mem_req_o=1, mem_addr_o = {tag,idx,0}; stays until mem_gnt_i; then -> FILL, beat cnt = 0.
//  FILL: each mem_rvalid_i cycle: write_o=1, word_o=cnt, wdata_o=mem_rdata_i (same cycle, no register);
//   instr_write_start_o=1 only when cnt==0. Gaps between beats allowed, outputs low during gaps.
//   After beat words-1: if ~second & need_next & ~hit_next (sampled at miss) -> REQ for idx+1, second=1;
//   else -> DONE.
//  DONE: one cycle for tag/valid array settle; -> IDLE, where lookup re-evaluates (expected hit).
//  stall_o = 1 in REQ, FILL, DONE.
//  Next line: idx+1 wraps mod block_no; at idx=block_no-1 next tag = tag+1 (wraps at tag width).
//  Request/fetch inputs (req_i, addr_i, hit_*) ignored outside IDLE; deassert of req_i mid-fill does not abort.
//  mem_rvalid_i in IDLE/REQ/DONE ignored (no write). mem_gnt_i outside REQ ignored.
//  mem_req_o asserted first cycle after miss; min miss penalty = 1(REQ)+words(FILL)+1(DONE) cycles.
//  Reset mid-operation: immediate return to IDLE, all outputs to reset values; memory side must drop burst.
// STRUCTURE
//  Package instr_cache_pkg: state enum, field widths (OFF_W=log2(words)+2, TAG_W), addr split functions
//   shared with tag compare and replacement stages.
//  Sub-module refill_beat_counter: log2(words)-bit counter, clear on grant, inc on rvalid, last flag.
// TESTING
//  Hit: req_i=1, hit_i=1, need_next_i=0 -> stall_o=0, no mem_req_o ever.
//  Single miss addr 0x0000_0140 (idx 20), gnt after 2 cycles, 4 back-to-back beats -> mem_addr_o=0x140,
//   write_o 4 cycles, word_o 0..3, instr_write_start_o only on beat 0, idx_o=20, DONE then stall_o=0.
//  Straddle miss at idx 63, hit_i=0, hit_next_i=0 -> two bursts, second idx_o=0, tag_o=tag+1, start pulses twice.
//  Beats with 1-cycle gaps and stray rvalid in IDLE -> write_o only on valid beats in FILL, none in IDLE.
//  rst_ni low during beat 2 -> async clear, write_o/mem_req_o=0 same cycle, IDLE after release, new miss restarts at word 0.

Source files
------------

// File: rtl/instr_cache_refill_ctrl_pkg.sv
// instr_cache_pkg: shared definitions for the instruction-cache refill path.
//   Default geometry (index/line/word widths), refill FSM state encoding and
//   address split helpers used by the tag compare, replacement and refill stages.
package instr_cache_pkg;

    localparam int IDX_SIZE = 6;
    localparam int BLOCK_NO = 1 << IDX_SIZE;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int WORDS    = 4;
    localparam int WORD_W   = $clog2(WORDS);
    localparam int OFF_W    = WORD_W + 2;               // word select + byte select
    localparam int TAG_W    = ADDR_W - IDX_SIZE - OFF_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_FILL,
        ST_DONE
    } refill_state_e;

    typedef logic [TAG_W-1:0]    tag_t;
    typedef logic [IDX_SIZE-1:0] idx_t;
    typedef logic [WORD_W-1:0]   word_t;

    function automatic tag_t addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic idx_t addr_idx(input logic [ADDR_W-1:0] a);
        return a[OFF_W +: IDX_SIZE];
    endfunction

    function automatic word_t addr_word(input logic [ADDR_W-1:0] a);
        return a[2 +: WORD_W];
    endfunction

endpackage

// File: rtl/instr_cache_refill_ctrl_if.sv
// Memory-side line read bus for the refill controller.
//   master (controller): mem_req/mem_addr out; mem_gnt, mem_rvalid, mem_rdata in.
//   slave  (memory)    : the mirror image.
interface instr_cache_refill_ctrl_if
    import instr_cache_pkg::*;
#(
    parameter int AW = ADDR_W,
    parameter int DW = DATA_W
) ();
    logic          mem_req;     // line read request, held until grant
    logic [AW-1:0] mem_addr;    // line-aligned address
    logic          mem_gnt;     // request accepted this cycle
    logic          mem_rvalid;  // one beat valid on mem_rdata
    logic [DW-1:0] mem_rdata;   // beat data, ascending word order

    modport master (output mem_req, mem_addr, input mem_gnt, mem_rvalid, mem_rdata);
    modport slave  (input mem_req, mem_addr, output mem_gnt, mem_rvalid, mem_rdata);
endinterface

// File: rtl/instr_cache_refill_ctrl_beat_counter.sv
// refill_beat_counter: word-slot counter for one line burst.
//   i_clr  : restart at word 0 (memory grant)
//   i_inc  : one beat written this cycle
//   o_cnt  : word slot of the beat currently on the bus
//   o_last : o_cnt is the final word of the line
module refill_beat_counter #(
    parameter  int WORDS = instr_cache_pkg::WORDS,
    localparam int CW    = $clog2(WORDS)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          i_clr,
    input  logic          i_inc,
    output logic [CW-1:0] o_cnt,
    output logic          o_last
);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)    r_cnt <= '0;
        else if (i_clr) r_cnt <= '0;
        else if (i_inc) r_cnt <= r_cnt + CW'(1);
    end

    assign o_cnt  = r_cnt;
    assign o_last = (r_cnt == CW'(WORDS - 1));

endmodule

// File: rtl/instr_cache_refill_ctrl.sv
// instr_cache_refill_ctrl: miss/refill controller for the 2-way I-cache.
//   Fetch side : req_i, addr_i, need_next_i, hit_i, hit_next_i in; stall_o out.
//   Memory side: mem (master modport) - line request/grant and beat return.
//   Array side : write_o, instr_write_start_o, idx_o, tag_o, word_o, wdata_o.
// A fetch that misses the current line and/or the straddled next line is
// serviced with one or two back-to-back line bursts, then one settle cycle.
module instr_cache_refill_ctrl
    import instr_cache_pkg::*;
#(
    parameter  int idx_size   = IDX_SIZE,
    parameter  int block_no   = BLOCK_NO,
    parameter  int addr_width = ADDR_W,
    parameter  int data_width = DATA_W,
    parameter  int words      = WORDS,
    localparam int WRD_W      = $clog2(words),
    localparam int OFS_W      = WRD_W + 2,
    localparam int TG_W       = addr_width - idx_size - OFS_W
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    input  logic [addr_width-1:0] addr_i,
    input  logic                  need_next_i,
    input  logic                  hit_i,
    input  logic                  hit_next_i,
    instr_cache_refill_ctrl_if.master mem,
    output logic                  write_o,
    output logic                  instr_write_start_o,
    output logic [idx_size-1:0]   idx_o,
    output logic [TG_W-1:0]       tag_o,
    output logic [WRD_W-1:0]      word_o,
    output logic [data_width-1:0] wdata_o,
    output logic                  stall_o
);

    localparam logic [idx_size-1:0] LAST_IDX = idx_size'(block_no - 1);

    refill_state_e         r_state, w_state_nxt;
    logic                  r_second, w_second_nxt;   // current fill is the idx+1 line
    logic                  r_pend_next, w_pend_nxt;  // next line also missed at lookup
    logic [TG_W-1:0]       r_tag, w_tag_nxt;
    logic [idx_size-1:0]   r_idx, w_idx_nxt;

    logic                  w_miss;
    logic                  w_req;
    logic                  w_write;
    logic                  w_stall;
    logic                  w_cnt_clr;
    logic [WRD_W-1:0]      w_cnt;
    logic                  w_last;
    logic [TG_W-1:0]       w_cur_tag;
    logic [idx_size-1:0]   w_cur_idx;
    logic                  w_unused_off;

    // Line following {t,i}: the index wraps and carries into the tag.
    function automatic logic [TG_W+idx_size-1:0] next_line(input logic [TG_W-1:0] t,
                                                           input logic [idx_size-1:0] i);
        return {(i == LAST_IDX) ? t + TG_W'(1) : t, i + idx_size'(1)};
    endfunction

    assign w_cur_tag    = addr_i[addr_width-1 -: TG_W];
    assign w_cur_idx    = addr_i[OFS_W +: idx_size];
    assign w_unused_off = ^addr_i[OFS_W-1:0];

    assign w_miss = req_i & (~hit_i | (need_next_i & ~hit_next_i));

    refill_beat_counter #(.WORDS(words)) u_beat_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .i_clr  (w_cnt_clr),
        .i_inc  (w_write),
        .o_cnt  (w_cnt),
        .o_last (w_last)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_second    <= 1'b0;
            r_pend_next <= 1'b0;
            r_tag       <= '0;
            r_idx       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_second    <= w_second_nxt;
            r_pend_next <= w_pend_nxt;
            r_tag       <= w_tag_nxt;
            r_idx       <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_second_nxt = r_second;
        w_pend_nxt   = r_pend_next;
        w_tag_nxt    = r_tag;
        w_idx_nxt    = r_idx;
        w_req        = 1'b0;
        w_write      = 1'b0;
        w_stall      = 1'b1;
        w_cnt_clr    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_stall = w_miss;
                if (w_miss) begin
                    // Current line first if it missed; otherwise only idx+1 is missing.
                    if (!hit_i) {w_tag_nxt, w_idx_nxt} = {w_cur_tag, w_cur_idx};
                    else        {w_tag_nxt, w_idx_nxt} = next_line(w_cur_tag, w_cur_idx);
                    w_second_nxt = hit_i;
                    w_pend_nxt   = need_next_i & ~hit_next_i;
                    w_state_nxt  = ST_REQ;
                end
            end
            ST_REQ: begin
                w_req = 1'b1;
                if (mem.mem_gnt) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                w_write = mem.mem_rvalid;
                if (mem.mem_rvalid && w_last) begin
                    if (!r_second && r_pend_next) begin
                        {w_tag_nxt, w_idx_nxt} = next_line(r_tag, r_idx);
                        w_second_nxt = 1'b1;
                        w_state_nxt  = ST_REQ;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // Settle cycle for the tag/valid arrays before lookup repeats.
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign mem.mem_req  = w_req;
    assign mem.mem_addr = {r_tag, r_idx, {OFS_W{1'b0}}};

    assign write_o             = w_write;
    assign instr_write_start_o = w_write & (w_cnt == '0);
    assign idx_o               = r_idx;
    assign tag_o               = r_tag;
    assign word_o              = w_cnt;
    assign wdata_o             = mem.mem_rdata;
    assign stall_o             = w_stall;

endmodule
